// File: rtl/sum_nbits_pipe.sv
// Pipelined incrementer: sum = data + carry. The carry chain is split into STAGES
// registered segments, with a valid/ready handshake and optional saturation on overflow.
module sum_nbits_pipe #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 3,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("sum_nbits_pipe: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  logic             valid_q    [STAGES];
  logic [WIDTH-1:0] word_q     [STAGES];
  logic             carry_q    [STAGES];

  logic             stage_vin  [STAGES];
  logic [WIDTH-1:0] stage_win  [STAGES];
  logic             stage_cin  [STAGES];
  logic [WIDTH-1:0] word_d     [STAGES];
  logic             carry_d    [STAGES];

  logic advance;

  // One global enable: the whole pipe moves together or holds together.
  assign advance = !valid_q[STAGES-1] | i_ready;

  always_comb begin
    stage_vin[0] = i_valid;
    stage_win[0] = i_data;
    stage_cin[0] = i_carry;
    for (int k = 1; k < int'(STAGES); k++) begin
      stage_vin[k] = valid_q[k-1];
      stage_win[k] = word_q[k-1];
      stage_cin[k] = carry_q[k-1];
    end
  end

  // Each stage ripples its carry-in through its own segment only.
  always_comb begin
    logic [WIDTH-1:0] w;
    logic             c;
    logic             s;
    w = '0;
    c = 1'b0;
    s = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      w = stage_win[k];
      c = stage_cin[k];
      for (int b = 0; b < int'(SEG); b++) begin
        s = w[k*int'(SEG) + b] ^ c;
        c = w[k*int'(SEG) + b] & c;
        w[k*int'(SEG) + b] = s;
      end
      if (SAT_EN && (k == int'(STAGES) - 1) && c) begin
        w = '1;
      end
      word_d[k]  = w;
      carry_d[k] = c;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        word_q[k]  <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= stage_vin[k];
        // Bubbles leave the data registers untouched so outputs hold their last value.
        if (stage_vin[k]) begin
          word_q[k]  <= word_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
    end
  end

  assign o_ready = advance;
  assign o_valid = valid_q[STAGES-1];
  assign o_sum   = word_q[STAGES-1];
  assign o_carry = carry_q[STAGES-1];

endmodule

// File: tb/tb_sum_nbits_pipe.sv
// Bench for sum_nbits_pipe: four instances (3/wrap, 3/sat, 1/wrap, 24/sat) share one stimulus.
module tb_sum_nbits_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv  = 1'b0;
  logic        ir  = 1'b1;
  logic        ic  = 1'b0;
  logic [23:0] id  = '0;

  logic        ov   [4];
  logic        ordy [4];
  logic [23:0] osum [4];
  logic        oc   [4];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sum_nbits_pipe #(.WIDTH(24), .STAGES(3), .SAT_EN(1'b0)) u_w3 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[0]), .i_data(id), .i_carry(ic),
    .o_valid(ov[0]), .i_ready(ir), .o_sum(osum[0]), .o_carry(oc[0])
  );
  sum_nbits_pipe #(.WIDTH(24), .STAGES(3), .SAT_EN(1'b1)) u_s3 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[1]), .i_data(id), .i_carry(ic),
    .o_valid(ov[1]), .i_ready(ir), .o_sum(osum[1]), .o_carry(oc[1])
  );
  sum_nbits_pipe #(.WIDTH(24), .STAGES(1), .SAT_EN(1'b0)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[2]), .i_data(id), .i_carry(ic),
    .o_valid(ov[2]), .i_ready(ir), .o_sum(osum[2]), .o_carry(oc[2])
  );
  sum_nbits_pipe #(.WIDTH(24), .STAGES(24), .SAT_EN(1'b1)) u_s24 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[3]), .i_data(id), .i_carry(ic),
    .o_valid(ov[3]), .i_ready(ir), .o_sum(osum[3]), .o_carry(oc[3])
  );

  // Inputs change on the falling edge; outputs are read 1 ns later, well before the rising edge.
  task automatic drive(input logic v, input logic [23:0] d, input logic c, input logic r);
    @(negedge clk);
    iv = v;
    id = d;
    ic = c;
    ir = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      n_vec++;
      if (ov[n] !== 1'b0 || osum[n] !== 24'h0 || oc[n] !== 1'b0 || ordy[n] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: valid=%b sum=%h carry=%b ready=%b, required 0/000000/0/1",
                 n, ov[n], osum[n], oc[n], ordy[n]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_and_check(input string name, input logic [23:0] d, input logic c,
                                input logic [23:0] exp_w, input logic [23:0] exp_s,
                                input logic exp_c);
    int lat;
    lat = 0;
    drive(1'b1, d, c, 1'b1);
    while (lat < 10 && ov[0] !== 1'b1) begin
      drive(1'b0, 24'h0, 1'b0, 1'b1);
      lat++;
    end
    n_vec++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required 3", name, lat);
    end
    n_vec++;
    if (osum[0] !== exp_w || oc[0] !== exp_c) begin
      n_fail++;
      $display("FAIL %s wrap: sum=%h carry=%b, required %h/%b", name, osum[0], oc[0], exp_w,
               exp_c);
    end
    n_vec++;
    if (ov[1] !== 1'b1 || osum[1] !== exp_s || oc[1] !== exp_c) begin
      n_fail++;
      $display("FAIL %s sat: valid=%b sum=%h carry=%b, required 1/%h/%b", name, ov[1], osum[1],
               oc[1], exp_s, exp_c);
    end
    drive(1'b0, 24'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [23:0] din  [5];
    logic        cin  [5];
    logic [24:0] dexp [5];
    int sent;
    int recv;
    din[0] = 24'h0000FF; cin[0] = 1'b1; dexp[0] = {1'b0, 24'h000100};
    din[1] = 24'h00FFFF; cin[1] = 1'b1; dexp[1] = {1'b0, 24'h010000};
    din[2] = 24'h123456; cin[2] = 1'b0; dexp[2] = {1'b0, 24'h123456};
    din[3] = 24'hFFFFFF; cin[3] = 1'b1; dexp[3] = {1'b1, 24'h000000};
    din[4] = 24'hABCDEF; cin[4] = 1'b1; dexp[4] = {1'b0, 24'hABCDF0};
    sent = 0;
    recv = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (sent < 5) drive(1'b1, din[sent], cin[sent], !(cyc >= 4 && cyc <= 6));
      else          drive(1'b0, 24'h0, 1'b0, !(cyc >= 4 && cyc <= 6));
      if (cyc >= 4 && cyc <= 6) begin
        n_vec++;
        if (ordy[0] !== 1'b0 || ov[0] !== 1'b1 || {oc[0], osum[0]} !== dexp[0]) begin
          n_fail++;
          $display("FAIL b2b stall c%0d: ready=%b valid=%b out=%h, required 0/1/%h", cyc,
                   ordy[0], ov[0], {oc[0], osum[0]}, dexp[0]);
        end
      end
      if (ov[0] === 1'b1 && ir) begin
        n_vec++;
        if (recv >= 5) begin
          n_fail++;
          $display("FAIL b2b extra word: out=%h, required none", {oc[0], osum[0]});
        end else begin
          if ({oc[0], osum[0]} !== dexp[recv]) begin
            n_fail++;
            $display("FAIL b2b word%0d: out=%h, required %h", recv, {oc[0], osum[0]},
                     dexp[recv]);
          end
          recv++;
        end
      end
      if (iv && ordy[0] === 1'b1) sent++;
    end
    n_vec++;
    if (recv != 5 || sent != 5) begin
      n_fail++;
      $display("FAIL b2b count: sent=%0d received=%0d, required 5/5", sent, recv);
    end
  endtask

  task automatic test_reset_flush();
    logic stale;
    drive(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
    drive(1'b1, 24'h00FFFF, 1'b1, 1'b0);
    drive(1'b1, 24'h0000FF, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    n_vec++;
    if (ov[0] !== 1'b1 || osum[0] !== 24'h5A5A5B) begin
      n_fail++;
      $display("FAIL flush pre: valid=%b sum=%h, required 1/5a5a5b", ov[0], osum[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (ov[0] !== 1'b0 || osum[0] !== 24'h0 || oc[0] !== 1'b0 || ordy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush async: valid=%b sum=%h carry=%b ready=%b, required 0/000000/0/1",
               ov[0], osum[0], oc[0], ordy[0]);
    end
    drive(1'b0, 24'h0, 1'b0, 1'b1);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 24'h0, 1'b0, 1'b1);
      for (int n = 0; n < 4; n++) if (ov[n] !== 1'b0) stale = 1'b1;
    end
    n_vec++;
    if (stale) begin
      n_fail++;
      $display("FAIL flush stale: a valid word appeared after reset, required none");
    end
  endtask

  task automatic test_random(input int cycles);
    logic [24:0] sb [4][64];
    int          wr [4];
    int          rd [4];
    logic [24:0] full;
    logic        v;
    logic        r;
    logic        c;
    logic [23:0] d;
    for (int n = 0; n < 4; n++) begin
      wr[n] = 0;
      rd[n] = 0;
    end
    rst = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      v = ($urandom_range(0, 3) != 0) && (cyc < cycles - 60);
      r = ($urandom_range(0, 3) != 0) || (cyc >= cycles - 60);
      c = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       d = 24'hFFFFFF;
        1:       d = 24'($urandom) | 24'h00FFFF;
        2:       d = 24'($urandom) | 24'h0000FF;
        default: d = 24'($urandom);
      endcase
      drive(v, d, c, r);
      for (int n = 0; n < 4; n++) begin
        if (ov[n] === 1'b1 && ir) begin
          n_vec++;
          if (rd[n] == wr[n]) begin
            n_fail++;
            $display("FAIL rand[%0d] unexpected word: out=%h, required none", n,
                     {oc[n], osum[n]});
          end else begin
            if ({oc[n], osum[n]} !== sb[n][rd[n] % 64]) begin
              n_fail++;
              $display("FAIL rand[%0d] word%0d: out=%h, required %h", n, rd[n],
                       {oc[n], osum[n]}, sb[n][rd[n] % 64]);
            end
            rd[n]++;
          end
        end
        if (iv && ordy[n] === 1'b1) begin
          full = {1'b0, id} + {24'h0, ic};
          if ((n == 1 || n == 3) && full[24]) full[23:0] = 24'hFFFFFF;
          sb[n][wr[n] % 64] = full;
          wr[n]++;
        end
      end
    end
    for (int n = 0; n < 4; n++) begin
      n_vec++;
      if (rd[n] != wr[n] || wr[n] < 100) begin
        n_fail++;
        $display("FAIL rand[%0d] count: accepted=%0d delivered=%0d, required equal", n, wr[n],
                 rd[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    send_and_check("seg_boundary", 24'h0000FF, 1'b1, 24'h000100, 24'h000100, 1'b0);
    send_and_check("overflow", 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF, 1'b1);
    send_and_check("passthru", 24'hA5A5A5, 1'b0, 24'hA5A5A5, 24'hA5A5A5, 1'b0);
    test_back_to_back();
    test_reset_flush();
    test_random(6000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
